// File: rtl/cbs_pkg.sv
// rtl/cbs_pkg.sv - shared constants, FSM encodings and window layout helper for the conv sequencer
package cbs_pkg;

  localparam int DEF_IMG_W = 5;
  localparam int DEF_IMG_H = 5;
  localparam int DEF_RES_W = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  // LSB of the byte for window row i, column k; row 0 / column 0 sit in the top byte.
  function automatic int dp_img_lsb(input int i, input int k);
    return 88 - 32 * i - 8 * k;
  endfunction

endpackage

// File: rtl/cbs_frame_buf.sv
// rtl/cbs_frame_buf.sv - frame store with raster write port and zero-padded 3x4 window read
module cbs_frame_buf
  import cbs_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [7:0]    row,
  input  logic [7:0]    col,
  output logic [95:0]   window
);

  logic [7:0] mem [IMG_W*IMG_H];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  genvar i, k;
  generate
    for (i = 0; i < 3; i++) begin : g_row
      for (k = 0; k < 4; k++) begin : g_col
        logic [8:0] rr;
        logic [8:0] cc;
        assign rr = {1'b0, row} + 9'(i);
        assign cc = {1'b0, col} + 9'(k);
        // The right-hand window of the last pass can run past the frame edge.
        assign window[dp_img_lsb(i, k) +: 8] =
          (cc < 9'(IMG_W) && rr < 9'(IMG_H)) ? mem[AW'(32'(rr) * IMG_W + 32'(cc))] : 8'h00;
      end
    end
  endgenerate

endmodule

// File: rtl/cbs_conv_sequencer.sv
// rtl/cbs_conv_sequencer.sv - buffers a frame and walks it through the dual-window 3x3 datapath
module cbs_conv_sequencer
  import cbs_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int RES_W = DEF_RES_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [71:0]        filter_in,
  output logic               busy,
  output logic               done,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [7:0]         pix_data,
  output logic [71:0]        dp_filter,
  output logic [95:0]        dp_img,
  input  logic [RES_W-1:0]   dp_res1,
  input  logic [RES_W-1:0]   dp_res2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*RES_W-1:0] out_data,
  output logic [1:0]         out_mask,
  output logic [7:0]         out_row,
  output logic [7:0]         out_col
);

  localparam int         NPIX = IMG_W * IMG_H;
  localparam int         AW   = $clog2(NPIX);
  localparam logic [8:0] OW   = 9'(IMG_W - 2);
  localparam logic [8:0] OH   = 9'(IMG_H - 2);

  logic [2:0]    state;
  logic [AW-1:0] pix_cnt;
  logic [7:0]    r;
  logic [7:0]    c;
  logic [95:0]   window;
  logic [8:0]    c_next;
  logic          pix_we;

  assign pix_we    = pix_valid && (state == S_LOAD);
  assign c_next    = {1'b0, c} + 9'd2;
  assign busy      = (state != S_IDLE);
  assign pix_ready = (state == S_LOAD);
  assign out_valid = (state == S_EMIT);
  assign done      = (state == S_FIN);

  cbs_frame_buf #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_frame_buf (
    .clk    (clk),
    .we     (pix_we),
    .waddr  (pix_cnt),
    .wdata  (pix_data),
    .row    (r),
    .col    (c),
    .window (window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      r         <= '0;
      c         <= '0;
      dp_filter <= '0;
      dp_img    <= '0;
      out_data  <= '0;
      out_mask  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dp_filter <= filter_in;
          pix_cnt   <= '0;
          r         <= '0;
          c         <= '0;
          state     <= S_LOAD;
        end
        S_LOAD: if (pix_valid) begin
          if (pix_cnt == AW'(NPIX - 1)) begin
            r     <= '0;
            c     <= '0;
            state <= S_ISSUE;
          end else begin
            pix_cnt <= pix_cnt + AW'(1);
          end
        end
        S_ISSUE: begin
          dp_img <= window;
          state  <= S_CAPTURE;
        end
        // Datapath is combinational on dp_img, so results are settled by the end of this cycle.
        S_CAPTURE: begin
          out_data <= {dp_res1, dp_res2};
          out_mask <= {1'b1, (({1'b0, c} + 9'd1) < OW)};
          out_row  <= r;
          out_col  <= c;
          state    <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          if (c_next >= OW) begin
            c <= '0;
            r <= r + 8'd1;
            state <= (({1'b0, r} + 9'd1) == OH) ? S_FIN : S_ISSUE;
          end else begin
            c     <= c_next[7:0];
            state <= S_ISSUE;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbs_conv_sequencer.sv
// tb/tb_cbs_conv_sequencer.sv - self-checking bench for cbs_conv_sequencer (5x5 and 6x3 instances)
module tb_cbs_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [1:0]  mask;
    logic [31:0] data;
  } res_t;

  typedef struct {
    int          pattern;   // 0 all ones, 1 raster index, 2 random
    bit          toggle;
    logic [71:0] filter;
    bit          from_table;
    int          n_res;
  } scen_t;

  // ---------------- DUT 1: 5x5 ----------------
  logic        start = 1'b0, pix_valid = 1'b0, out_ready = 1'b1;
  logic [71:0] filter_in = '0;
  logic [7:0]  pix_data = '0;
  logic        busy, done, pix_ready, out_valid;
  logic [71:0] dp_filter;
  logic [95:0] dp_img;
  logic [15:0] dp_res1, dp_res2;
  logic [31:0] out_data;
  logic [1:0]  out_mask;
  logic [7:0]  out_row, out_col;

  cbs_conv_sequencer #(.IMG_W(5), .IMG_H(5), .RES_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter_in(filter_in), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .dp_filter(dp_filter), .dp_img(dp_img), .dp_res1(dp_res1), .dp_res2(dp_res2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .out_row(out_row), .out_col(out_col)
  );

  // ---------------- DUT 2: 6x3 ----------------
  logic        start2 = 1'b0, pix_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [71:0] filter_in2 = '0;
  logic [7:0]  pix_data2 = '0;
  logic        busy2, done2, pix_ready2, out_valid2;
  logic [71:0] dp_filter2;
  logic [95:0] dp_img2;
  logic [15:0] dp_res1_2, dp_res2_2;
  logic [31:0] out_data2;
  logic [1:0]  out_mask2;
  logic [7:0]  out_row2, out_col2;

  cbs_conv_sequencer #(.IMG_W(6), .IMG_H(3), .RES_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .filter_in(filter_in2), .busy(busy2), .done(done2),
    .pix_valid(pix_valid2), .pix_ready(pix_ready2), .pix_data(pix_data2),
    .dp_filter(dp_filter2), .dp_img(dp_img2), .dp_res1(dp_res1_2), .dp_res2(dp_res2_2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_mask(out_mask2),
    .out_row(out_row2), .out_col(out_col2)
  );

  // Dual 3x3 MAC datapath; tap (i,j) is filter byte 3i+j counted from the top byte.
  function automatic logic [15:0] dp_mac(input logic [71:0] f, input logic [95:0] img, input int off);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += 16'(f[71 - 8 * (3 * i + j) -: 8]) * 16'(img[88 - 32 * i - 8 * (j + off) +: 8]);
    return acc;
  endfunction

  always_comb begin
    dp_res1   = dp_mac(dp_filter, dp_img, 0);
    dp_res2   = dp_mac(dp_filter, dp_img, 1);
    dp_res1_2 = dp_mac(dp_filter2, dp_img2, 0);
    dp_res2_2 = dp_mac(dp_filter2, dp_img2, 1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] frame1 [25];
  logic [7:0] filt [9];
  res_t sbq[$];
  res_t vec1 [6];
  res_t vec2 [2];
  scen_t scen [4];

  function automatic logic [15:0] ref_mac(input int r, input int c);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (c + j < 5) acc += 16'(filt[3 * i + j]) * 16'(frame1[(r + i) * 5 + c + j]);
    return acc;
  endfunction

  task automatic push_model();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c += 2)
        sbq.push_back('{8'(r), 8'(c), {1'b1, (c + 1 < 3)}, {ref_mac(r, c), ref_mac(r, c + 1)}});
  endtask

  int hs1 = 0, done1 = 0, hs2 = 0, done2_cnt = 0;

  always @(negedge clk) begin
    res_t got, e;
    if (out_valid && out_ready) begin
      got = '{out_row, out_col, out_mask, out_data};
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0h expected none", got);
      end else begin
        e = sbq.pop_front();
        chk("result", 128'(got), 128'(e));
      end
      hs1++;
    end
    if (done) done1++;
  end

  always @(negedge clk) begin
    res_t got;
    if (out_valid2 && out_ready2) begin
      got = '{out_row2, out_col2, out_mask2, out_data2};
      if (hs2 < 2) chk("w6_result", 128'(got), 128'(vec2[hs2]));
      else begin checks++; errors++; $display("FAIL w6_extra_result: got %0h expected none", got); end
      hs2++;
    end
    if (done2) begin
      done2_cnt++;
      chk("w6_done_after_last", 128'(hs2), 128'(2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_frame(input int pattern, input logic [71:0] f);
    for (int n = 0; n < 25; n++)
      frame1[n] = (pattern == 0) ? 8'h01 : (pattern == 1) ? 8'(n) : 8'($urandom_range(0, 255));
    for (int t = 0; t < 9; t++) filt[t] = f[71 - 8 * t -: 8];
  endtask

  task automatic start_and_load(input logic [71:0] f, input bit toggle);
    int idx;
    @(negedge clk); filter_in = f; start = 1'b1;
    @(negedge clk); start = 1'b0; filter_in = ~f;
    idx = 0;
    for (int cyc = 0; cyc < 1000 && idx < 25; cyc++) begin
      @(negedge clk);
      pix_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = frame1[idx];
      start     = toggle && (cyc % 7 == 3);
      if (pix_valid && pix_ready) idx++;
    end
    @(negedge clk); pix_valid = 1'b0; start = 1'b0;
    chk("pixels_loaded", 128'(idx), 128'(25));
  endtask

  task automatic wait_done(input int base);
    for (int cyc = 0; cyc < 2000 && done1 == base; cyc++) @(negedge clk);
    chk("done_seen", 128'(done1 != base), 128'(1));
  endtask

  task automatic wait_valid();
    int cyc;
    for (cyc = 0; cyc < 500 && !out_valid; cyc++) @(negedge clk);
    chk("out_valid_seen", 128'(out_valid), 128'(1));
  endtask

  task automatic run_frame(input scen_t s);
    int bh, bd;
    fill_frame(s.pattern, s.filter);
    if (s.from_table) for (int n = 0; n < 6; n++) sbq.push_back(vec1[n]);
    else push_model();
    bh = hs1; bd = done1;
    start_and_load(s.filter, s.toggle);
    wait_done(bd);
    repeat (3) @(negedge clk);
    chk("n_results", 128'(hs1 - bh), 128'(s.n_res));
    chk("done_pulses", 128'(done1 - bd), 128'(1));
    chk("sb_drained", 128'(sbq.size()), 128'(0));
    chk("busy_idle", 128'(busy), 128'(0));
  endtask

  localparam logic [71:0] F_ONES = {9{8'h01}};
  localparam logic [71:0] F_SEQ  = 72'h01_02_03_04_05_06_07_08_09;

  initial begin
    int bh, bd;
    logic [31:0] held;
    vec1[0] = '{8'd0, 8'd0, 2'b11, 32'h00090009};
    vec1[1] = '{8'd0, 8'd2, 2'b10, 32'h00090006};
    vec1[2] = '{8'd1, 8'd0, 2'b11, 32'h00090009};
    vec1[3] = '{8'd1, 8'd2, 2'b10, 32'h00090006};
    vec1[4] = '{8'd2, 8'd0, 2'b11, 32'h00090009};
    vec1[5] = '{8'd2, 8'd2, 2'b10, 32'h00090006};
    vec2[0] = '{8'd0, 8'd0, 2'b11, 32'h003F0048};
    vec2[1] = '{8'd0, 8'd2, 2'b11, 32'h0051005A};
    scen[0] = '{0, 1'b0, F_ONES, 1'b1, 6};
    scen[1] = '{1, 1'b0, F_ONES, 1'b0, 6};
    scen[2] = '{0, 1'b1, F_ONES, 1'b1, 6};
    scen[3] = '{2, 1'b1, F_SEQ,  1'b0, 6};

    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_pix_ready", 128'(pix_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_fields", 128'({out_data, out_mask, out_row, out_col}), 128'(0));
    chk("rst_dp", 128'({dp_img, dp_filter}), 128'(0));
    @(negedge clk); rst_n = 1'b1;

    for (int n = 0; n < 4; n++) run_frame(scen[n]);

    // Backpressure: hold out_ready low through the first EMIT.
    fill_frame(1, F_ONES); push_model();
    bh = hs1; bd = done1;
    @(posedge clk); #1 out_ready = 1'b0;
    start_and_load(F_ONES, 1'b0);
    wait_valid();
    chk("first_dp_img", 128'(dp_img), 128'(96'h00010203_05060708_0A0B0C0D));
    chk("first_out_data", 128'(out_data), 128'(32'h0036003F));
    held = out_data;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_data", 128'(out_data), 128'(held));
      chk("stall_pos", 128'({out_row, out_col}), 128'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(bd);
    chk("stall_n_results", 128'(hs1 - bh), 128'(6));

    // Reset asserted during the third EMIT.
    fill_frame(0, F_ONES); push_model();
    bh = hs1; bd = done1;
    start_and_load(F_ONES, 1'b0);
    for (int cyc = 0; cyc < 500 && hs1 < bh + 2; cyc++) @(negedge clk);
    chk("two_results_before_reset", 128'(hs1 - bh), 128'(2));
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_busy_done", 128'({out_valid, busy, done, pix_ready}), 128'(0));
    chk("midrst_out_fields", 128'({out_data, out_mask, out_row, out_col}), 128'(0));
    chk("midrst_dp", 128'({dp_img, dp_filter}), 128'(0));
    sbq.delete();
    @(negedge clk); @(negedge clk);
    chk("midrst_no_done", 128'(done1 - bd), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1 out_ready = 1'b1;
    run_frame(scen[3]);

    // 6x3 instance: single output row, both passes fully valid.
    @(negedge clk); filter_in2 = F_ONES; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 200 && idx < 18; cyc++) begin
        @(negedge clk);
        pix_valid2 = 1'b1; pix_data2 = 8'(idx);
        if (pix_ready2) idx++;
      end
      @(negedge clk); pix_valid2 = 1'b0;
      chk("w6_pixels_loaded", 128'(idx), 128'(18));
    end
    for (int cyc = 0; cyc < 500 && done2_cnt == 0; cyc++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("w6_n_results", 128'(hs2), 128'(2));
    chk("w6_done_pulses", 128'(done2_cnt), 128'(1));
    chk("w6_busy_idle", 128'(busy2), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
